// File: rtl/padframe_pkg.sv
// rtl/padframe_pkg.sv - shared types and constants for the GPIO padframe controller
package padframe_pkg;

  localparam int CFG_W     = 10;
  localparam int CFG_OE    = 0;
  localparam int CFG_A     = 1;
  localparam int CFG_IE    = 2;
  localparam int CFG_PU    = 3;
  localparam int CFG_PD    = 4;
  localparam int CFG_CS    = 5;
  localparam int CFG_SL    = 6;
  localparam int CFG_PDRV0 = 7;
  localparam int CFG_PDRV1 = 8;
  localparam int CFG_IRQEN = 9;

  // Field order matches the bit indices above, MSB first.
  typedef struct packed {
    logic irqen;
    logic pdrv1;
    logic pdrv0;
    logic sl;
    logic cs;
    logic pd;
    logic pu;
    logic ie;
    logic a;
    logic oe;
  } pad_cfg_t;

  // Input enabled with pull-down: a safe, non-driving pad after reset.
  localparam pad_cfg_t CFG_RST = 10'b00_0001_0100;

  localparam logic [5:0] BCAST_ADDR = 6'd63;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } gpio_state_t;

endpackage

// File: rtl/pad_in_sync.sv
// rtl/pad_in_sync.sv - three-flop pad input synchroniser with edge detect
module pad_in_sync #(
  parameter int NPADS = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPADS-1:0] i_y,
  output logic [NPADS-1:0] o_y_sync,
  output logic [NPADS-1:0] o_rise,
  output logic [NPADS-1:0] o_fall
);

  logic [NPADS-1:0] r_y1;
  logic [NPADS-1:0] r_y2;
  logic [NPADS-1:0] r_y3;

  // Two flops settle metastability; the third holds the previous value for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y1 <= '0;
      r_y2 <= '0;
      r_y3 <= '0;
    end else begin
      r_y1 <= i_y;
      r_y2 <= r_y1;
      r_y3 <= r_y2;
    end
  end

  assign o_y_sync = r_y2;
  assign o_rise   = r_y2 & ~r_y3;
  assign o_fall   = ~r_y2 & r_y3;

endmodule

// File: rtl/padframe_gpio_ctrl.sv
// rtl/padframe_gpio_ctrl.sv - core-side GPIO padframe controller (config, sweep, edge flags)
module padframe_gpio_ctrl
  import padframe_pkg::*;
#(
  parameter int         NPADS      = 46,
  parameter int         GROUP      = 8,
  parameter logic [5:0] BCAST_ADDR = padframe_pkg::BCAST_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [5:0]       wr_addr,
  input  logic [9:0]       wr_data,
  output logic             wr_err,
  input  logic             rd_en,
  input  logic [5:0]       rd_addr,
  output logic             rd_valid,
  output logic [12:0]      rd_data,
  output logic             irq,
  output logic [NPADS-1:0] bidir_OE,
  output logic [NPADS-1:0] bidir_A,
  output logic [NPADS-1:0] bidir_IE,
  output logic [NPADS-1:0] bidir_PU,
  output logic [NPADS-1:0] bidir_PD,
  output logic [NPADS-1:0] bidir_CS,
  output logic [NPADS-1:0] bidir_SL,
  output logic [NPADS-1:0] bidir_PDRV0,
  output logic [NPADS-1:0] bidir_PDRV1,
  input  logic [NPADS-1:0] bidir_Y
);

  gpio_state_t      r_state;
  gpio_state_t      w_state_nxt;
  pad_cfg_t         r_cfg [NPADS];
  pad_cfg_t         r_bdata;
  logic [6:0]       r_idx;
  logic [NPADS-1:0] r_rise;
  logic [NPADS-1:0] r_fall;
  logic             r_wr_err;
  logic             r_rd_valid;
  logic [12:0]      r_rd_data;
  logic             r_irq;

  logic             w_fire;
  logic             w_addr_pad;
  logic             w_last;
  logic [NPADS-1:0] w_y_sync;
  logic [NPADS-1:0] w_rise;
  logic [NPADS-1:0] w_fall;
  logic [NPADS-1:0] w_clr;
  logic [NPADS-1:0] w_irqen;
  logic [12:0]      w_rd_word;

  pad_in_sync #(.NPADS(NPADS)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_y      (bidir_Y),
    .o_y_sync (w_y_sync),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_fire     = wr_valid && wr_ready;
  assign w_addr_pad = ({1'b0, wr_addr} < 7'(NPADS));
  assign w_last     = ((r_idx + 7'(GROUP)) >= 7'(NPADS));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and write-port handshake.
  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (w_fire && wr_addr == BCAST_ADDR) w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Broadcast data and group pointer; only meaningful while sweeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bdata <= CFG_RST;
      r_idx   <= '0;
    end else if (w_fire && wr_addr == BCAST_ADDR) begin
      r_bdata <= wr_data;
      r_idx   <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_idx   <= r_idx + 7'(GROUP);
    end
  end

  // Per-pad config: sweep group write, or single-pad write while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPADS; p++) r_cfg[p] <= CFG_RST;
    end else begin
      for (int p = 0; p < NPADS; p++) begin
        if (r_state == ST_SWEEP && 7'(p) >= r_idx && 7'(p) < (r_idx + 7'(GROUP)))
          r_cfg[p] <= r_bdata;
        else if (w_fire && wr_addr == 6'(p))
          r_cfg[p] <= wr_data;
      end
    end
  end

  // Read-clear mask, IRQ enables, read mux and pad control fan-out.
  always_comb begin
    w_clr       = '0;
    w_irqen     = '0;
    w_rd_word   = '0;
    bidir_OE    = '0;
    bidir_A     = '0;
    bidir_IE    = '0;
    bidir_PU    = '0;
    bidir_PD    = '0;
    bidir_CS    = '0;
    bidir_SL    = '0;
    bidir_PDRV0 = '0;
    bidir_PDRV1 = '0;
    for (int p = 0; p < NPADS; p++) begin
      if (rd_addr == 6'(p)) begin
        w_clr[p]  = rd_en;
        w_rd_word = {r_fall[p], r_rise[p], w_y_sync[p], r_cfg[p]};
      end
      w_irqen[p]     = r_cfg[p].irqen;
      bidir_OE[p]    = r_cfg[p].oe;
      bidir_A[p]     = r_cfg[p].a;
      bidir_IE[p]    = r_cfg[p].ie;
      bidir_PU[p]    = r_cfg[p].pu;
      bidir_PD[p]    = r_cfg[p].pd;
      bidir_CS[p]    = r_cfg[p].cs;
      bidir_SL[p]    = r_cfg[p].sl;
      bidir_PDRV0[p] = r_cfg[p].pdrv0;
      bidir_PDRV1[p] = r_cfg[p].pdrv1;
    end
  end

  // Sticky edge flags, read-to-clear with detection taking priority; registered irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_rise <= w_rise | (r_rise & ~w_clr);
      r_fall <= w_fall | (r_fall & ~w_clr);
      r_irq  <= |((r_rise | r_fall) & w_irqen);
    end
  end

  // Registered read response and invalid-address write error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_word;
      r_wr_err   <= w_fire && !w_addr_pad && (wr_addr != BCAST_ADDR);
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign wr_err   = r_wr_err;
  assign irq      = r_irq;

endmodule

// File: tb/tb_padframe_gpio_ctrl.sv
// tb/tb_padframe_gpio_ctrl.sv - self-checking bench for padframe_gpio_ctrl
module tb_padframe_gpio_ctrl;

  localparam int N  = 46;
  localparam int G  = 8;
  localparam logic [N-1:0] ALL = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid, wr_ready, wr_err, rd_en, rd_valid, irq;
  logic [5:0]   wr_addr, rd_addr;
  logic [9:0]   wr_data;
  logic [12:0]  rd_data;
  logic [N-1:0] bidir_OE, bidir_A, bidir_IE, bidir_PU, bidir_PD;
  logic [N-1:0] bidir_CS, bidir_SL, bidir_PDRV0, bidir_PDRV1, bidir_Y;

  int total = 0;
  int bad   = 0;

  padframe_gpio_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .irq(irq),
    .bidir_OE(bidir_OE), .bidir_A(bidir_A), .bidir_IE(bidir_IE), .bidir_PU(bidir_PU),
    .bidir_PD(bidir_PD), .bidir_CS(bidir_CS), .bidir_SL(bidir_SL),
    .bidir_PDRV0(bidir_PDRV0), .bidir_PDRV1(bidir_PDRV1), .bidir_Y(bidir_Y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per-pad config words, a count of remaining sweep groups,
  // a history of sampled pad inputs, and sticky flags.
  logic [9:0]   m_cfg [N];
  logic [9:0]   m_bdata;
  int           m_left, m_base;
  logic [N-1:0] h1, h2, h3, m_rise, m_fall;
  logic         m_wr_err, m_rd_valid, m_irq;
  logic [12:0]  m_rd_data;

  initial forever begin : model
    logic [N-1:0] dr, df, clr;
    logic         pirq;
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int p = 0; p < N; p++) m_cfg[p] = 10'h014;
      m_left = 0; m_base = 0; m_bdata = 0;
      h1 = 0; h2 = 0; h3 = 0; m_rise = 0; m_fall = 0;
      m_wr_err = 0; m_rd_valid = 0; m_irq = 0; m_rd_data = 0;
    end else begin
      pirq = 1'b0;
      for (int p = 0; p < N; p++) if ((m_rise[p] | m_fall[p]) & m_cfg[p][9]) pirq = 1'b1;
      dr = h2 & ~h3;
      df = ~h2 & h3;
      clr = 0;
      m_rd_valid = rd_en;
      if (rd_en) begin
        if (rd_addr < N) begin
          m_rd_data = {m_fall[rd_addr], m_rise[rd_addr], h2[rd_addr], m_cfg[rd_addr]};
          clr[rd_addr] = 1'b1;
        end else m_rd_data = 0;
      end
      m_rise = dr | (m_rise & ~clr);
      m_fall = df | (m_fall & ~clr);
      m_wr_err = 0;
      if (m_left == 0) begin
        if (wr_valid) begin
          if (wr_addr < N) m_cfg[wr_addr] = wr_data;
          else if (wr_addr == 63) begin
            m_bdata = wr_data; m_base = 0; m_left = (N + G - 1) / G;
          end else m_wr_err = 1;
        end
      end else begin
        for (int g = 0; g < G; g++) if (m_base + g < N) m_cfg[m_base + g] = m_bdata;
        m_base += G;
        m_left--;
      end
      h3 = h2; h2 = h1; h1 = bidir_Y;
      m_irq = pirq;
    end
  end

  function automatic logic [N-1:0] mvec(input int b);
    logic [N-1:0] r;
    for (int p = 0; p < N; p++) r[p] = m_cfg[p][b];
    return r;
  endfunction

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("OE", bidir_OE, mvec(0));
      chk("A", bidir_A, mvec(1));
      chk("IE", bidir_IE, mvec(2));
      chk("PU", bidir_PU, mvec(3));
      chk("PD", bidir_PD, mvec(4));
      chk("CS", bidir_CS, mvec(5));
      chk("SL", bidir_SL, mvec(6));
      chk("PDRV0", bidir_PDRV0, mvec(7));
      chk("PDRV1", bidir_PDRV1, mvec(8));
      chk("wr_ready", wr_ready, m_left == 0);
      chk("wr_err", wr_err, m_wr_err);
      chk("irq", irq, m_irq);
      chk("rd_valid", rd_valid, m_rd_valid);
      if (m_rd_valid) chk("rd_data", rd_data, m_rd_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [9:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    while (!wr_ready && n < 20) begin tick(); n++; end
    if (n == 20) chk("write_timeout", 1, 0);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] oe_snap;
    logic [N-1:0] exp_oe;
    wr_valid = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; bidir_Y = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_IE", bidir_IE, ALL);
    chk("rst_PD", bidir_PD, ALL);
    chk("rst_OE", bidir_OE, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    tick();

    // Single-pad write and read-back.
    do_write(6'd5, 10'h003);
    chk("wr5_OE", bidir_OE, 46'h20);
    chk("wr5_A", bidir_A, 46'h20);
    chk("wr5_IE", bidir_IE, ALL & ~46'h20);
    do_read(6'd5);
    chk("rd5_valid", rd_valid, 1);
    chk("rd5_data", rd_data, 13'h003);
    tick();
    chk("rd5_valid_drop", rd_valid, 0);

    // Broadcast with a second write held pending during the sweep.
    wr_valid = 1'b1; wr_addr = 6'd63; wr_data = 10'h001;
    tick();
    wr_addr = 6'd3; wr_data = 10'h000;
    chk("bc_ready0", wr_ready, 0);
    chk("bc_oe0", bidir_OE, 46'h20);
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_oe = (k * 8 >= N) ? ALL : ((46'd1 << (k * 8)) - 46'd1);
      chk("bc_oe", bidir_OE, exp_oe | 46'h20);
      chk("bc_ready", wr_ready, (k == 6));
    end
    tick();
    wr_valid = 1'b0;
    chk("held_wr_pad3", bidir_OE, ALL & ~46'h8);

    // Invalid address.
    oe_snap = bidir_OE;
    do_write(6'd50, 10'h3ff);
    chk("inv_err", wr_err, 1);
    chk("inv_oe", bidir_OE, oe_snap);
    tick();
    chk("inv_err_drop", wr_err, 0);
    do_read(6'd50);
    chk("inv_rd_valid", rd_valid, 1);
    chk("inv_rd_data", rd_data, 0);

    // Edge capture on pad 12.
    do_write(6'd12, 10'h204);
    bidir_Y[12] = 1'b1;
    tick(); tick(); tick();
    chk("edge_irq_e3", irq, 0);
    tick();
    chk("edge_irq_e4", irq, 1);
    do_read(6'd12);
    chk("edge_rd_rise", rd_data, 13'hE04);
    tick();
    chk("edge_irq_clear", irq, 0);
    do_read(6'd12);
    chk("edge_rd_cleared", rd_data, 13'h604);
    bidir_Y[12] = 1'b0;
    tick(); tick(); tick(); tick();
    do_read(6'd12);
    chk("edge_rd_fall", rd_data, 13'h1204);
    tick();
    bidir_Y[12] = 1'b1;
    tick(); tick();
    rd_en = 1'b1; rd_addr = 6'd12;
    tick();
    rd_en = 1'b0;
    chk("setwin_rd", rd_data, 13'h604);
    do_read(6'd12);
    chk("setwin_kept", rd_data, 13'hE04);

    // Reset during the third sweep cycle.
    wr_valid = 1'b1; wr_addr = 6'd63; wr_data = 10'h2c3;
    tick();
    wr_valid = 1'b0;
    tick(); tick();
    chk("mid_oe_groups", bidir_OE[15:0], 16'hffff);
    rst = 1'b1;
    #1;
    chk("mid_rst_IE", bidir_IE, ALL);
    chk("mid_rst_PD", bidir_PD, ALL);
    chk("mid_rst_OE", bidir_OE, 0);
    chk("mid_rst_A", bidir_A, 0);
    chk("mid_rst_ready", wr_ready, 1);
    chk("mid_rst_irq", irq, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", wr_ready, 1);
    chk("post_rst_PDRV1", bidir_PDRV1, 0);
    do_write(6'd0, 10'h001);
    chk("post_rst_wr", bidir_OE, 46'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
